// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, pcselect encoding, fetch FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        PC_NEXT = 3'd0,
        PC_JR   = 3'd1,
        PC_BR   = 3'd2,
        PC_J    = 3'd3
    } pcsel_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    localparam word_t HALT_WORD = 32'hFFFF_FFFF;

    function automatic logic is_redirect_sel(input logic [2:0] sel);
        return (sel == PC_JR) || (sel == PC_BR) || (sel == PC_J);
    endfunction

endpackage

// File: rtl/npc_target.sv
// Combinational redirect-target mux for JR, branch and jump redirects from EX.
module npc_target
    import cpu_types_pkg::*;
(
    input  logic [2:0]  i_sel,
    input  word_t       i_rs_data,
    input  logic [15:0] i_br_imm,
    input  word_t       i_ex_npc,
    input  logic [25:0] i_jump_index,
    output word_t       o_target
);

    word_t w_br_offset;

    assign w_br_offset = {{14{i_br_imm[15]}}, i_br_imm, 2'b00};

    // Select the redirect target for the current pcselect code
    always_comb begin
        o_target = 32'h0000_0000;
        case (i_sel)
            PC_JR:   o_target = {i_rs_data[31:2], 2'b00};
            PC_BR:   o_target = i_ex_npc + w_br_offset;
            PC_J:    o_target = {i_ex_npc[31:28], i_jump_index, 2'b00};
            default: o_target = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads imem, fills the IF/ID register
// and latches HALT once decode reports it.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
)(
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        halt_in,
    input  logic        redirect_en,
    input  logic [2:0]  redirect_sel,
    input  logic [31:0] rs_data,
    input  logic [15:0] br_imm,
    input  logic [31:0] ex_npc,
    input  logic [25:0] jump_index,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_npc,
    output logic        ifid_valid,
    output logic [31:0] pc,
    output logic        halted,
    output logic [31:0] fetch_count
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    word_t        r_pc;
    word_t        r_ifid_instr;
    word_t        r_ifid_npc;
    logic         r_ifid_valid;
    word_t        r_fetch_count;
    word_t        w_target;
    word_t        w_pc_plus4;
    logic         w_take_redirect;
    logic         w_enter_halt;

    npc_target u_npc_target (
        .i_sel        (redirect_sel),
        .i_rs_data    (rs_data),
        .i_br_imm     (br_imm),
        .i_ex_npc     (ex_npc),
        .i_jump_index (jump_index),
        .o_target     (w_target)
    );

    assign w_take_redirect = redirect_en & is_redirect_sel(redirect_sel);
    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_enter_halt    = (r_state == RUN) && (w_state_next == HALT);

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a redirect flushes the younger HALT, so it blocks halting
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN: begin
                if (halt_in && r_ifid_valid && !w_take_redirect) begin
                    w_state_next = HALT;
                end else begin
                    w_state_next = RUN;
                end
            end
            HALT:    w_state_next = HALT;
            default: w_state_next = RUN;
        endcase
    end

    // PC, IF/ID and fetch counter; everything freezes once halted
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc          <= PC_INIT;
            r_ifid_instr  <= 32'h0000_0000;
            r_ifid_npc    <= 32'h0000_0000;
            r_ifid_valid  <= 1'b0;
            r_fetch_count <= 32'h0000_0000;
        end else if (r_state == RUN) begin
            if (w_take_redirect) begin
                r_pc         <= w_target;
                r_ifid_instr <= 32'h0000_0000;
                r_ifid_npc   <= 32'h0000_0000;
                r_ifid_valid <= 1'b0;
            end else if (w_enter_halt || (!stall && !ihit)) begin
                r_ifid_instr <= 32'h0000_0000;
                r_ifid_npc   <= 32'h0000_0000;
                r_ifid_valid <= 1'b0;
            end else if (!stall) begin
                r_pc          <= w_pc_plus4;
                r_ifid_instr  <= imemload;
                r_ifid_npc    <= w_pc_plus4;
                r_ifid_valid  <= 1'b1;
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign imemaddr    = r_pc;
    assign imemREN     = (r_state == RUN);
    assign pc          = r_pc;
    assign ifid_instr  = r_ifid_instr;
    assign ifid_npc    = r_ifid_npc;
    assign ifid_valid  = r_ifid_valid;
    assign halted      = (r_state == HALT);
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences
// and randomized traffic checked against a behavioural fetch model.
module tb_fetch_unit;

    logic        CLK, RST, ihit, stall, halt_in, redirect_en;
    logic [31:0] imemload, rs_data, ex_npc;
    logic [2:0]  redirect_sel;
    logic [15:0] br_imm;
    logic [25:0] jump_index;
    logic        imemREN, ifid_valid, halted;
    logic [31:0] imemaddr, ifid_instr, ifid_npc, pc, fetch_count;
    logic        w2_ren, w2_valid, w2_halted;
    logic [31:0] w2_addr, w2_instr, w2_npc, w2_pc, w2_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_pc, m_instr, m_npc, m_cnt;
    logic        m_valid, m_halted;

    fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
        .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall), .halt_in(halt_in),
        .redirect_en(redirect_en), .redirect_sel(redirect_sel), .rs_data(rs_data),
        .br_imm(br_imm), .ex_npc(ex_npc), .jump_index(jump_index),
        .ifid_instr(ifid_instr), .ifid_npc(ifid_npc), .ifid_valid(ifid_valid),
        .pc(pc), .halted(halted), .fetch_count(fetch_count));

    fetch_unit #(.PC_INIT(32'hFFFF_FFFC)) dut_wrap (
        .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
        .imemREN(w2_ren), .imemaddr(w2_addr), .stall(stall), .halt_in(halt_in),
        .redirect_en(redirect_en), .redirect_sel(redirect_sel), .rs_data(rs_data),
        .br_imm(br_imm), .ex_npc(ex_npc), .jump_index(jump_index),
        .ifid_instr(w2_instr), .ifid_npc(w2_npc), .ifid_valid(w2_valid),
        .pc(w2_pc), .halted(w2_halted), .fetch_count(w2_cnt));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic        ihit;
        logic [31:0] load;
        logic        stall, halt, ren;
        logic [2:0]  sel;
        logic [31:0] rs;
        logic [15:0] imm;
        logic [31:0] enpc;
        logic [25:0] jidx;
        logic [31:0] e_pc, e_instr, e_npc;
        logic        e_valid, e_halted;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tv[15];

    function automatic vec_t mk(logic ih, logic [31:0] ld, logic st, logic hl, logic re,
                                logic [2:0] sl, logic [31:0] rs, logic [15:0] im,
                                logic [31:0] en, logic [25:0] ji, logic [31:0] epc,
                                logic [31:0] ein, logic [31:0] enp, logic ev, logic eh,
                                logic [31:0] ec);
        vec_t v;
        v.ihit = ih; v.load = ld; v.stall = st; v.halt = hl; v.ren = re; v.sel = sl;
        v.rs = rs; v.imm = im; v.enpc = en; v.jidx = ji; v.e_pc = epc; v.e_instr = ein;
        v.e_npc = enp; v.e_valid = ev; v.e_halted = eh; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_npc, input logic e_valid, input logic e_halted,
                           input logic [31:0] e_cnt);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".imemaddr"}, imemaddr, e_pc);
        chk({tag, ".imemREN"}, {31'd0, imemREN}, {31'd0, ~e_halted});
        chk({tag, ".ifid_instr"}, ifid_instr, e_instr);
        if (!$isunknown(e_npc)) chk({tag, ".ifid_npc"}, ifid_npc, e_npc);
        chk({tag, ".ifid_valid"}, {31'd0, ifid_valid}, {31'd0, e_valid});
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, e_halted});
        chk({tag, ".fetch_count"}, fetch_count, e_cnt);
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_npc = 32'h0; m_cnt = 32'h0;
        m_valid = 1'b0; m_halted = 1'b0;
    endtask

    // Architectural view of one clock edge; bubble npc is left as don't-care
    task automatic model_step();
        int off;
        if (!m_halted) begin
            if (redirect_en && redirect_sel >= 3'd1 && redirect_sel <= 3'd3) begin
                off = int'($signed(br_imm));
                if (redirect_sel == 3'd1)      m_pc = rs_data & 32'hFFFF_FFFC;
                else if (redirect_sel == 3'd2) m_pc = ex_npc + 32'(off * 4);
                else                           m_pc = (ex_npc & 32'hF000_0000) | ({6'd0, jump_index} << 2);
                m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0;
            end else if (halt_in && m_valid) begin
                m_halted = 1'b1; m_instr = 32'h0; m_npc = 'x; m_valid = 1'b0;
            end else if (stall) begin
                m_cnt = m_cnt;
            end else if (ihit) begin
                m_instr = imemload; m_pc = m_pc + 32'd4; m_npc = m_pc;
                m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
            end else begin
                m_instr = 32'h0; m_npc = 'x; m_valid = 1'b0;
            end
        end
    endtask

    task automatic tick(input string tag);
        @(posedge CLK);
        model_step();
        #1;
        chk_all(tag, m_pc, m_instr, m_npc, m_valid, m_halted, m_cnt);
    endtask

    task automatic clr_in();
        ihit = 1'b0; imemload = 32'h0; stall = 1'b0; halt_in = 1'b0; redirect_en = 1'b0;
        redirect_sel = 3'd0; rs_data = 32'h0; br_imm = 16'h0; ex_npc = 32'h0; jump_index = 26'h0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
    endtask

    initial begin
        RST = 1'b1;
        clr_in();
        model_reset();
        tv[0]  = mk(1, 32'h2401_0005, 0, 0, 0, 3'd0, 32'h0, 16'h0, 32'h0, 26'h0, 32'h4, 32'h2401_0005, 32'h4, 1, 0, 32'd1);
        tv[1]  = mk(1, 32'h2402_0007, 0, 0, 0, 3'd0, 32'h0, 16'h0, 32'h0, 26'h0, 32'h8, 32'h2402_0007, 32'h8, 1, 0, 32'd2);
        tv[2]  = mk(0, 32'hAAAA_AAAA, 0, 0, 0, 3'd0, 32'h0, 16'h0, 32'h0, 26'h0, 32'h8, 32'h0, 'x, 0, 0, 32'd2);
        tv[3]  = mk(0, 32'hAAAA_AAAA, 0, 0, 0, 3'd0, 32'h0, 16'h0, 32'h0, 26'h0, 32'h8, 32'h0, 'x, 0, 0, 32'd2);
        tv[4]  = mk(0, 32'hAAAA_AAAA, 0, 0, 0, 3'd0, 32'h0, 16'h0, 32'h0, 26'h0, 32'h8, 32'h0, 'x, 0, 0, 32'd2);
        tv[5]  = mk(1, 32'h0000_0020, 0, 0, 0, 3'd0, 32'h0, 16'h0, 32'h0, 26'h0, 32'hC, 32'h20, 32'hC, 1, 0, 32'd3);
        tv[6]  = mk(1, 32'hDEAD_BEEF, 1, 0, 0, 3'd0, 32'h0, 16'h0, 32'h0, 26'h0, 32'hC, 32'h20, 32'hC, 1, 0, 32'd3);
        tv[7]  = mk(1, 32'hDEAD_BEEF, 1, 0, 0, 3'd0, 32'h0, 16'h0, 32'h0, 26'h0, 32'hC, 32'h20, 32'hC, 1, 0, 32'd3);
        tv[8]  = mk(1, 32'hDEAD_BEEF, 1, 0, 1, 3'd2, 32'h0, 16'hFFFE, 32'h104, 26'h0, 32'hFC, 32'h0, 32'h0, 0, 0, 32'd3);
        tv[9]  = mk(1, 32'h1111_1111, 0, 0, 0, 3'd0, 32'h0, 16'h0, 32'h0, 26'h0, 32'h100, 32'h1111_1111, 32'h100, 1, 0, 32'd4);
        tv[10] = mk(1, 32'h3333_3333, 0, 0, 1, 3'd3, 32'h0, 16'h0, 32'h4000_0010, 26'h40, 32'h4000_0100, 32'h0, 32'h0, 0, 0, 32'd4);
        tv[11] = mk(1, 32'h3333_3333, 0, 0, 1, 3'd1, 32'h203, 16'h0, 32'h0, 26'h0, 32'h200, 32'h0, 32'h0, 0, 0, 32'd4);
        tv[12] = mk(1, 32'h2222_2222, 0, 0, 1, 3'd5, 32'h0, 16'h0, 32'h0, 26'h0, 32'h204, 32'h2222_2222, 32'h204, 1, 0, 32'd5);
        tv[13] = mk(1, 32'h4444_4444, 0, 1, 0, 3'd0, 32'h0, 16'h0, 32'h0, 26'h0, 32'h204, 32'h0, 'x, 0, 1, 32'd5);
        tv[14] = mk(1, 32'h5555_5555, 0, 0, 1, 3'd3, 32'h0, 16'h0, 32'h4000_0010, 26'h40, 32'h204, 32'h0, 'x, 0, 1, 32'd5);

        do_reset();
        #1;
        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 15; i++) begin
            ihit = tv[i].ihit; imemload = tv[i].load; stall = tv[i].stall; halt_in = tv[i].halt;
            redirect_en = tv[i].ren; redirect_sel = tv[i].sel; rs_data = tv[i].rs;
            br_imm = tv[i].imm; ex_npc = tv[i].enpc; jump_index = tv[i].jidx;
            tick($sformatf("tv%0d.model", i));
            chk_all($sformatf("tv%0d", i), tv[i].e_pc, tv[i].e_instr, tv[i].e_npc,
                    tv[i].e_valid, tv[i].e_halted, tv[i].e_cnt);
        end

        // Redirect and HALT together: the jump wins and halting is suppressed
        clr_in();
        do_reset();
        ihit = 1'b1; imemload = 32'h2401_0005;
        tick("jh.fetch");
        halt_in = 1'b1; redirect_en = 1'b1; redirect_sel = 3'd3;
        ex_npc = 32'h4000_0010; jump_index = 26'h40;
        tick("jh.redir");
        chk_all("jh.redir.k", 32'h4000_0100, 32'h0, 32'h0, 1'b0, 1'b0, 32'd1);
        clr_in();
        ihit = 1'b1; imemload = 32'h0000_0042;
        tick("jh.after");
        chk_all("jh.after.k", 32'h4000_0104, 32'h42, 32'h4000_0104, 1'b1, 1'b0, 32'd2);

        // PC wrap on the second instance, then asynchronous reset mid-run
        clr_in();
        do_reset();
        chk("wrap.pc0", w2_pc, 32'hFFFF_FFFC);
        ihit = 1'b1; imemload = 32'hABCD_0001;
        tick("wrap.t0");
        chk("wrap.pc", w2_pc, 32'h0);
        chk("wrap.npc", w2_npc, 32'h0);
        chk("wrap.valid", {31'd0, w2_valid}, 32'd1);
        chk("wrap.instr", w2_instr, 32'hABCD_0001);
        tick("wrap.t1");
        chk("wrap.pc2", w2_pc, 32'h4);
        #2 RST = 1'b1;
        #1;
        chk_all("arst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("arst.w2pc", w2_pc, 32'hFFFF_FFFC);
        chk("arst.w2cnt", w2_cnt, 32'h0);
        chk("arst.w2valid", {31'd0, w2_valid}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();

        // Randomized traffic against the model, with a reset every 100 cycles
        for (int c = 0; c < 600; c++) begin
            if (c % 100 == 0) begin
                clr_in();
                do_reset();
            end
            ihit         = ($urandom_range(0, 3) != 0);
            imemload     = $urandom;
            stall        = ($urandom_range(0, 4) == 0);
            halt_in      = ($urandom_range(0, 39) == 0);
            redirect_en  = ($urandom_range(0, 4) == 0);
            redirect_sel = 3'($urandom_range(0, 7));
            rs_data      = $urandom;
            br_imm       = 16'($urandom);
            ex_npc       = $urandom;
            jump_index   = 26'($urandom);
            tick($sformatf("rnd%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
